// File: rtl/ccip_avmm_pkg.sv
// Shared CCI-P c0 types and Avalon-to-CCI-P read bridge constants/helpers.
package ccip_avmm_pkg;

  localparam int unsigned CCIP_CLADDR_W  = 42;
  localparam int unsigned CCIP_CLDATA_BW = 512;
  localparam int unsigned CCIP_MDATA_W   = 16;

  localparam int unsigned CCIP_AVMM_ROB_DEFAULT_DEPTH = 64;
  localparam int unsigned CCIP_AVMM_MAX_BURST         = 16;

  typedef enum logic [1:0] {
    eVC_VA  = 2'h0,
    eVC_VL0 = 2'h1,
    eVC_VH0 = 2'h2,
    eVC_VH1 = 2'h3
  } t_ccip_vc;

  typedef enum logic [1:0] {
    eCL_LEN_1 = 2'h0,
    eCL_LEN_2 = 2'h1,
    eCL_LEN_4 = 2'h3
  } t_ccip_clLen;

  typedef enum logic [3:0] {
    eREQ_RDLINE_I = 4'h0,
    eREQ_RDLINE_S = 4'h1
  } t_ccip_c0_req;

  typedef enum logic [3:0] {
    eRSP_RDLINE = 4'h0,
    eRSP_UMSG   = 4'h4
  } t_ccip_c0_rsp;

  typedef struct packed {
    t_ccip_vc           vc_sel;
    logic [1:0]         rsvd1;
    t_ccip_clLen        cl_len;
    t_ccip_c0_req       req_type;
    logic [5:0]         rsvd0;
    logic [CCIP_CLADDR_W-1:0] address;
    logic [CCIP_MDATA_W-1:0]  mdata;
  } t_ccip_c0_ReqMemHdr;

  typedef struct packed {
    t_ccip_vc           vc_used;
    logic               rsvd1;
    logic               hit_miss;
    logic [1:0]         rsvd0;
    logic [1:0]         cl_num;
    t_ccip_c0_rsp       resp_type;
    logic [CCIP_MDATA_W-1:0] mdata;
  } t_ccip_c0_RspMemHdr;

  typedef struct packed {
    t_ccip_c0_ReqMemHdr hdr;
    logic               valid;
  } t_if_ccip_c0_Tx;

  typedef struct packed {
    t_ccip_c0_RspMemHdr        hdr;
    logic [CCIP_CLDATA_BW-1:0] data;
    logic                      rspValid;
    logic                      mmioRdValid;
    logic                      mmioWrValid;
  } t_if_ccip_c0_Rx;

  typedef enum logic {
    ST_IDLE,
    ST_SPLIT
  } t_rd_cmd_state;

  // Largest legal naturally-aligned chunk for the remaining lines at this CL address.
  function automatic t_ccip_clLen t_rd_chunk_len(input logic [15:0] rem,
                                                 input logic [1:0]  cl_addr_lo);
    if (rem >= 16'd4 && cl_addr_lo == 2'b00) return eCL_LEN_4;
    else if (rem >= 16'd2 && !cl_addr_lo[0]) return eCL_LEN_2;
    else return eCL_LEN_1;
  endfunction

  function automatic logic [2:0] cl_len_lines(input t_ccip_clLen len);
    case (len)
      eCL_LEN_4: return 3'd4;
      eCL_LEN_2: return 3'd2;
      default:   return 3'd1;
    endcase
  endfunction

endpackage

// File: rtl/avmm_ccip_rd_rob.sv
// Read reorder buffer: slot allocation, out-of-order fill, in-order drain.
module avmm_ccip_rd_rob
  import ccip_avmm_pkg::*;
#(
  parameter int unsigned DATA_W = 512,
  parameter int unsigned DEPTH  = CCIP_AVMM_ROB_DEFAULT_DEPTH,
  parameter int unsigned IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              alloc_i,
  input  logic [2:0]        alloc_len_i,
  output logic [IDX_W:0]    free_o,
  output logic [IDX_W-1:0]  tail_o,
  input  logic              wr_en_i,
  input  logic [IDX_W-1:0]  wr_idx_i,
  input  logic [DATA_W-1:0] wr_data_i,
  output logic              rd_valid_o,
  output logic [DATA_W-1:0] rd_data_o
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  valid_q;
  logic [IDX_W:0]    head_q, tail_q;
  logic              rd_valid_q;
  logic [DATA_W-1:0] rd_data_q;
  logic [IDX_W-1:0]  head_idx;
  logic              drain;

  assign head_idx   = head_q[IDX_W-1:0];
  assign drain      = valid_q[head_idx];
  assign free_o     = (IDX_W+1)'(DEPTH) - (tail_q - head_q);
  assign tail_o     = tail_q[IDX_W-1:0];
  assign rd_valid_o = rd_valid_q;
  assign rd_data_o  = rd_data_q;

  // Response data write port.
  always_ff @(posedge clk) begin
    if (wr_en_i) mem[wr_idx_i] <= wr_data_i;
  end

  // Registered read of the head slot.
  always_ff @(posedge clk) begin
    if (drain) rd_data_q <= mem[head_idx];
  end

  // Pointers, valid bits and drain strobe; fill and drain never target the same slot.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q    <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= drain;
      if (drain) begin
        valid_q[head_idx] <= 1'b0;
        head_q            <= head_q + 1'b1;
      end
      if (wr_en_i) valid_q[wr_idx_i] <= 1'b1;
      if (alloc_i) tail_q <= tail_q + (IDX_W+1)'(alloc_len_i);
    end
  end

endmodule

// File: rtl/avmm_ccip_host_rd_rob.sv
// Avalon-MM burst read slave to CCI-P c0: splits bursts into aligned chunks, reorders replies.
module avmm_ccip_host_rd_rob
  import ccip_avmm_pkg::*;
#(
  parameter int unsigned ADDR_W    = 48,
  parameter int unsigned DATA_W    = 512,
  parameter int unsigned MAX_BURST = CCIP_AVMM_MAX_BURST,
  parameter int unsigned BURST_W   = $clog2(MAX_BURST) + 1,
  parameter int unsigned DEPTH     = CCIP_AVMM_ROB_DEFAULT_DEPTH
) (
  input  logic                clk,
  input  logic                reset,
  output logic                avmm_waitrequest,
  output logic [DATA_W-1:0]   avmm_readdata,
  output logic                avmm_readdatavalid,
  input  logic [ADDR_W-1:0]   avmm_address,
  input  logic                avmm_read,
  input  logic [BURST_W-1:0]  avmm_burstcount,
  input  logic                c0TxAlmFull,
  input  t_if_ccip_c0_Rx      c0rx,
  output t_if_ccip_c0_Tx      c0tx
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned CLA_W = ADDR_W - 6;

  t_rd_cmd_state      state_q, state_d;
  logic [CLA_W-1:0]   cl_addr_q, cl_addr_d;
  logic [BURST_W-1:0] rem_q, rem_d;
  logic               almfull_q;
  t_if_ccip_c0_Tx     c0tx_q;
  t_ccip_c0_ReqMemHdr req_hdr;
  t_ccip_clLen        len_enc;
  logic [2:0]         len_lines;
  logic [IDX_W:0]     free;
  logic [IDX_W-1:0]   tail_idx;
  logic [IDX_W-1:0]   rsp_idx;
  logic               accept, issue, rsp_wr;
  logic               unused_in;

  assign avmm_waitrequest = (state_q == ST_SPLIT) | almfull_q;
  assign accept    = avmm_read & ~avmm_waitrequest;
  assign len_enc   = t_rd_chunk_len(16'(rem_q), cl_addr_q[1:0]);
  assign len_lines = cl_len_lines(len_enc);
  assign issue     = (state_q == ST_SPLIT) & ~almfull_q & (free >= (IDX_W+1)'(len_lines));
  assign rsp_wr    = c0rx.rspValid & (c0rx.hdr.resp_type == eRSP_RDLINE);
  assign rsp_idx   = c0rx.hdr.mdata[IDX_W-1:0] + IDX_W'(c0rx.hdr.cl_num);
  assign c0tx      = c0tx_q;
  assign unused_in = ^{avmm_address[5:0], c0rx.hdr, c0rx.mmioRdValid, c0rx.mmioWrValid};

  // Command FSM and chunk splitter next-state.
  always_comb begin
    state_d   = state_q;
    cl_addr_d = cl_addr_q;
    rem_d     = rem_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          cl_addr_d = avmm_address[ADDR_W-1:6];
          rem_d     = avmm_burstcount;
          state_d   = ST_SPLIT;
        end
      end
      ST_SPLIT: begin
        if (issue) begin
          cl_addr_d = cl_addr_q + CLA_W'(len_lines);
          rem_d     = rem_q - BURST_W'(len_lines);
          if (rem_q == BURST_W'(len_lines)) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Request header for the chunk under consideration; mdata carries its first ROB slot.
  always_comb begin
    req_hdr          = '0;
    req_hdr.vc_sel   = eVC_VH0;
    req_hdr.req_type = eREQ_RDLINE_I;
    req_hdr.cl_len   = len_enc;
    req_hdr.address  = CCIP_CLADDR_W'(cl_addr_q);
    req_hdr.mdata    = CCIP_MDATA_W'(tail_idx);
  end

  // FSM state and registered almost-full.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cl_addr_q <= '0;
      rem_q     <= '0;
      almfull_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      cl_addr_q <= cl_addr_d;
      rem_q     <= rem_d;
      almfull_q <= c0TxAlmFull;
    end
  end

  // CCI-P c0 request register; valid is a one-cycle pulse per chunk.
  always_ff @(posedge clk) begin
    if (reset) begin
      c0tx_q <= '0;
    end else begin
      c0tx_q.valid <= issue;
      if (issue) c0tx_q.hdr <= req_hdr;
    end
  end

  avmm_ccip_rd_rob #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_rob (
    .clk         (clk),
    .reset       (reset),
    .alloc_i     (issue),
    .alloc_len_i (len_lines),
    .free_o      (free),
    .tail_o      (tail_idx),
    .wr_en_i     (rsp_wr),
    .wr_idx_i    (rsp_idx),
    .wr_data_i   (c0rx.data),
    .rd_valid_o  (avmm_readdatavalid),
    .rd_data_o   (avmm_readdata)
  );

endmodule

// File: tb/tb_avmm_ccip_host_rd_rob.sv
// Directed bench for the Avalon-to-CCI-P read bridge (default ROB and an 8-entry ROB).
module tb_avmm_ccip_host_rd_rob;
  import ccip_avmm_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // Default-parameter instance
  logic           wr, rdv, rd;
  logic [511:0]   rdata;
  logic [47:0]    addr;
  logic [4:0]     bc;
  logic           almf;
  t_if_ccip_c0_Rx c0rx;
  t_if_ccip_c0_Tx c0tx;

  // DEPTH=8 instance
  logic           wr8, rdv8, rd8;
  logic [511:0]   rdata8;
  logic [47:0]    addr8;
  logic [4:0]     bc8;
  logic           almf8;
  t_if_ccip_c0_Rx c0rx8;
  t_if_ccip_c0_Tx c0tx8;

  avmm_ccip_host_rd_rob u_dut (
    .clk(clk), .reset(reset), .avmm_waitrequest(wr), .avmm_readdata(rdata),
    .avmm_readdatavalid(rdv), .avmm_address(addr), .avmm_read(rd),
    .avmm_burstcount(bc), .c0TxAlmFull(almf), .c0rx(c0rx), .c0tx(c0tx)
  );

  avmm_ccip_host_rd_rob #(.DEPTH(8)) u_dut8 (
    .clk(clk), .reset(reset), .avmm_waitrequest(wr8), .avmm_readdata(rdata8),
    .avmm_readdatavalid(rdv8), .avmm_address(addr8), .avmm_read(rd8),
    .avmm_burstcount(bc8), .c0TxAlmFull(almf8), .c0rx(c0rx8), .c0tx(c0tx8)
  );

  typedef struct {
    logic [41:0] addr;
    t_ccip_clLen len;
    logic [15:0] mdata;
    int          cyc;
  } tx_rec_t;

  tx_rec_t      txq[$], tx8q[$];
  logic [511:0] rdq[$], rd8q[$];
  int           rdcq[$], rd8cq[$];
  int           cyc = 0;
  int           asserts = 0;
  int           errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitors sample on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (c0tx.valid)  txq.push_back('{c0tx.hdr.address, c0tx.hdr.cl_len, c0tx.hdr.mdata, cyc});
    if (c0tx8.valid) tx8q.push_back('{c0tx8.hdr.address, c0tx8.hdr.cl_len, c0tx8.hdr.mdata, cyc});
    if (rdv)  begin rdq.push_back(rdata);   rdcq.push_back(cyc);  end
    if (rdv8) begin rd8q.push_back(rdata8); rd8cq.push_back(cyc); end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [511:0] pat(input int n);
    logic [511:0] v;
    for (int i = 0; i < 16; i++) v[i*32 +: 32] = 32'(n * 16 + i) ^ 32'h5A5A_0000;
    return v;
  endfunction

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic send(input bit sel, input logic [47:0] a, input logic [4:0] b, output int acc);
    int n;
    n = 0;
    while ((sel ? wr8 : wr) && n < 100) begin step(); n++; end
    asserts++;
    if (sel ? wr8 : wr) begin
      $display("FAIL send_accept: waitrequest=1 expected 0 after %0d cycles", n);
      errors++;
    end
    if (sel) begin rd8 = 1'b1; addr8 = a; bc8 = b; end
    else     begin rd  = 1'b1; addr  = a; bc  = b; end
    acc = cyc;
    step();
    rd8 = 1'b0;
    rd  = 1'b0;
  endtask

  task automatic respond(input bit sel, input logic [15:0] md, input logic [1:0] cln,
                         input t_ccip_c0_rsp rt, input logic [511:0] d);
    t_if_ccip_c0_Rx r;
    r = '0;
    r.rspValid      = 1'b1;
    r.hdr.vc_used   = eVC_VH0;
    r.hdr.mdata     = md;
    r.hdr.cl_num    = cln;
    r.hdr.resp_type = rt;
    r.data          = d;
    if (sel) c0rx8 = r; else c0rx = r;
    step();
    c0rx8 = '0;
    c0rx  = '0;
  endtask

  task automatic wait_tx(input bit sel, input int n, input int budget, input string name);
    int k;
    k = 0;
    while ((sel ? tx8q.size() : txq.size()) < n && k < budget) begin step(); k++; end
    asserts++;
    if ((sel ? tx8q.size() : txq.size()) < n) begin
      $display("FAIL %s: requests seen %0d expected %0d", name, sel ? tx8q.size() : txq.size(), n);
      errors++;
    end
  endtask

  task automatic wait_rd(input bit sel, input int n, input int budget, input string name);
    int k;
    k = 0;
    while ((sel ? rd8q.size() : rdq.size()) < n && k < budget) begin step(); k++; end
    asserts++;
    if ((sel ? rd8q.size() : rdq.size()) < n) begin
      $display("FAIL %s: readdata beats %0d expected %0d", name, sel ? rd8q.size() : rdq.size(), n);
      errors++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) step();
    asserts++;
    if ({wr, c0tx.valid, rdv, wr8} !== 4'b1001) begin
      $display("FAIL reset_state: {wr,txv,rdv,wr8}=%b expected 1001", {wr, c0tx.valid, rdv, wr8});
      errors++;
    end
    reset = 1'b0;
    asserts++;
    if (wr !== 1'b1) begin
      $display("FAIL reset_first_cycle_wr: got %b expected 1", wr); errors++;
    end
    step();
    asserts++;
    if (wr !== 1'b0) begin
      $display("FAIL reset_release_wr: got %b expected 0", wr); errors++;
    end
  endtask

  task automatic test_burst1();
    int acc, r;
    txq.delete(); rdq.delete(); rdcq.delete();
    send(0, 48'h1000, 5'd1, acc);
    wait_tx(0, 1, 20, "burst1_tx");
    if (txq.size() > 0) begin
      asserts++;
      if (txq[0].addr !== 42'h40 || txq[0].len !== eCL_LEN_1 || txq[0].mdata !== 16'd0 || txq[0].cyc != acc + 2) begin
        $display("FAIL burst1_hdr: addr=%h len=%0d mdata=%0d cyc=%0d expected 40 0 0 %0d",
                 txq[0].addr, txq[0].len, txq[0].mdata, txq[0].cyc, acc + 2);
        errors++;
      end
    end
    // A non-read response must not fill the slot.
    respond(0, 16'd0, 2'd0, eRSP_UMSG, pat(99));
    repeat (4) step();
    asserts++;
    if (rdq.size() != 0) begin
      $display("FAIL umsg_ignored: readdata beats %0d expected 0", rdq.size()); errors++;
    end
    r = cyc;
    respond(0, 16'd0, 2'd0, eRSP_RDLINE, pat(1));
    wait_rd(0, 1, 20, "burst1_rd");
    if (rdq.size() > 0) begin
      asserts++;
      if (rdq[0] !== pat(1) || rdcq[0] != r + 2) begin
        $display("FAIL burst1_data: data=%h cyc=%0d expected %h cyc=%0d", rdq[0], rdcq[0], pat(1), r + 2);
        errors++;
      end
    end
  endtask

  task automatic test_burst4_reorder();
    int acc, r;
    txq.delete(); rdq.delete(); rdcq.delete();
    send(0, 48'h0, 5'd4, acc);
    wait_tx(0, 1, 20, "burst4_tx");
    if (txq.size() > 0) begin
      asserts++;
      if (txq[0].addr !== 42'h0 || txq[0].len !== eCL_LEN_4 || txq[0].mdata !== 16'd1) begin
        $display("FAIL burst4_hdr: addr=%h len=%0d mdata=%0d expected 0 3 1",
                 txq[0].addr, txq[0].len, txq[0].mdata);
        errors++;
      end
    end
    r = cyc;
    for (int i = 3; i >= 0; i--) respond(0, 16'd1, 2'(i), eRSP_RDLINE, pat(10 + i));
    wait_rd(0, 4, 20, "burst4_rd");
    for (int i = 0; i < 4 && i < rdq.size(); i++) begin
      asserts++;
      if (rdq[i] !== pat(10 + i) || rdcq[i] != r + 5 + i) begin
        $display("FAIL burst4_order[%0d]: data=%h cyc=%0d expected %h cyc=%0d",
                 i, rdq[i], rdcq[i], pat(10 + i), r + 5 + i);
        errors++;
      end
    end
  endtask

  task automatic test_split();
    int acc;
    int ea[3] = '{1, 2, 4};
    int em[3] = '{5, 6, 8};
    t_ccip_clLen el[3] = '{eCL_LEN_1, eCL_LEN_2, eCL_LEN_1};
    txq.delete();
    send(0, 48'h40, 5'd4, acc);
    wait_tx(0, 3, 20, "split_tx");
    for (int i = 0; i < 3 && i < txq.size(); i++) begin
      asserts++;
      if (txq[i].addr !== 42'(ea[i]) || txq[i].len !== el[i] || txq[i].mdata !== 16'(em[i]) || txq[i].cyc != acc + 2 + i) begin
        $display("FAIL split_chunk[%0d]: addr=%h len=%0d mdata=%0d cyc=%0d expected %h %0d %0d %0d",
                 i, txq[i].addr, txq[i].len, txq[i].mdata, txq[i].cyc, ea[i], el[i], em[i], acc + 2 + i);
        errors++;
      end
    end
    txq.delete();
    send(0, 48'h0, 5'd16, acc);
    wait_tx(0, 4, 20, "burst16_tx");
    for (int i = 0; i < 4 && i < txq.size(); i++) begin
      asserts++;
      if (txq[i].addr !== 42'(4 * i) || txq[i].len !== eCL_LEN_4 || txq[i].mdata !== 16'(9 + 4 * i) || txq[i].cyc != acc + 2 + i) begin
        $display("FAIL burst16_chunk[%0d]: addr=%h len=%0d mdata=%0d cyc=%0d expected %h 3 %0d %0d",
                 i, txq[i].addr, txq[i].len, txq[i].mdata, txq[i].cyc, 4 * i, 9 + 4 * i, acc + 2 + i);
        errors++;
      end
    end
  endtask

  task automatic test_almfull();
    int acc;
    txq.delete();
    send(0, 48'h4000, 5'd16, acc);
    wait_tx(0, 1, 20, "almfull_first_tx");
    almf = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      asserts++;
      if (wr !== 1'b1) begin
        $display("FAIL almfull_wr[%0d]: got %b expected 1", i, wr); errors++;
      end
    end
    asserts++;
    if (txq.size() != 2) begin
      $display("FAIL almfull_slack: requests %0d expected 2", txq.size()); errors++;
    end
    almf = 1'b0;
    wait_tx(0, 4, 20, "almfull_resume_tx");
    for (int i = 0; i < 4 && i < txq.size(); i++) begin
      asserts++;
      if (txq[i].addr !== 42'(32'h100 + 4 * i) || txq[i].len !== eCL_LEN_4 || txq[i].mdata !== 16'(25 + 4 * i)) begin
        $display("FAIL almfull_chunk[%0d]: addr=%h len=%0d mdata=%0d expected %h 3 %0d",
                 i, txq[i].addr, txq[i].len, txq[i].mdata, 32'h100 + 4 * i, 25 + 4 * i);
        errors++;
      end
    end
  endtask

  task automatic test_reset_midsplit();
    int acc;
    txq.delete();
    send(0, 48'h8000, 5'd16, acc);
    wait_tx(0, 1, 20, "midsplit_first_tx");
    reset = 1'b1;
    step();
    reset = 1'b0;
    asserts++;
    if ({c0tx.valid, rdv, wr} !== 3'b001) begin
      $display("FAIL midsplit_reset_state: {txv,rdv,wr}=%b expected 001", {c0tx.valid, rdv, wr});
      errors++;
    end
    txq.delete();
    send(0, 48'h80, 5'd1, acc);
    wait_tx(0, 1, 20, "post_reset_tx");
    repeat (5) step();
    asserts++;
    if (txq.size() != 1) begin
      $display("FAIL post_reset_count: requests %0d expected 1", txq.size()); errors++;
    end
    if (txq.size() > 0) begin
      asserts++;
      if (txq[0].addr !== 42'h2 || txq[0].len !== eCL_LEN_1 || txq[0].mdata !== 16'd0) begin
        $display("FAIL post_reset_hdr: addr=%h len=%0d mdata=%0d expected 2 0 0",
                 txq[0].addr, txq[0].len, txq[0].mdata);
        errors++;
      end
    end
  endtask

  task automatic test_rob_full();
    int a, r;
    tx8q.delete(); rd8q.delete(); rd8cq.delete();
    send(1, 48'h0, 5'd4, a);
    send(1, 48'h100, 5'd4, a);
    wait_tx(1, 2, 20, "rob8_fill_tx");
    for (int i = 0; i < 2 && i < tx8q.size(); i++) begin
      asserts++;
      if (tx8q[i].addr !== 42'(4 * i) || tx8q[i].len !== eCL_LEN_4 || tx8q[i].mdata !== 16'(4 * i)) begin
        $display("FAIL rob8_chunk[%0d]: addr=%h len=%0d mdata=%0d expected %h 3 %0d",
                 i, tx8q[i].addr, tx8q[i].len, tx8q[i].mdata, 4 * i, 4 * i);
        errors++;
      end
    end
    send(1, 48'h200, 5'd4, a);
    repeat (8) step();
    asserts++;
    if (tx8q.size() != 2 || wr8 !== 1'b1) begin
      $display("FAIL rob8_full_stall: requests=%0d wr=%b expected 2 1", tx8q.size(), wr8);
      errors++;
    end
    r = cyc;
    for (int i = 0; i < 4; i++) respond(1, 16'd0, 2'(i), eRSP_RDLINE, pat(20 + i));
    wait_tx(1, 3, 20, "rob8_resume_tx");
    if (tx8q.size() > 2) begin
      asserts++;
      if (tx8q[2].addr !== 42'h8 || tx8q[2].len !== eCL_LEN_4 || tx8q[2].mdata !== 16'd0 || tx8q[2].cyc != r + 6) begin
        $display("FAIL rob8_resume_hdr: addr=%h len=%0d mdata=%0d cyc=%0d expected 8 3 0 %0d",
                 tx8q[2].addr, tx8q[2].len, tx8q[2].mdata, tx8q[2].cyc, r + 6);
        errors++;
      end
    end
    wait_rd(1, 4, 20, "rob8_rd");
    if (rd8q.size() > 3) begin
      asserts++;
      if (rd8q[3] !== pat(23) || rd8cq[3] != r + 5) begin
        $display("FAIL rob8_last_data: data=%h cyc=%0d expected %h cyc=%0d", rd8q[3], rd8cq[3], pat(23), r + 5);
        errors++;
      end
    end
  endtask

  initial begin
    rd = 1'b0; addr = '0; bc = '0; almf = 1'b0; c0rx = '0;
    rd8 = 1'b0; addr8 = '0; bc8 = '0; almf8 = 1'b0; c0rx8 = '0;
    test_reset();
    test_burst1();
    test_burst4_reorder();
    test_split();
    test_almfull();
    test_reset_midsplit();
    test_rob_full();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, errors);
    $finish;
  end

endmodule
